// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if
//   Bundles the pipeline request/response signals and the data-memory bus
//   of the MEM-stage access controller.
//   master : pipeline + memory environment (drives requests and mem_rdata)
//   slave  : the access controller itself
//   Request side : req_valid, req_write, req_size, req_signed, req_addr,
//                  req_wdata -> stall, load_data, load_valid, err
//   Memory side  : mem_addr, mem_wdata, MemRead, MemWrite -> mem_rdata
interface dmem_access_ctrl_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        MemRead;
  logic        MemWrite;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_rdata,
    input  stall, load_data, load_valid, err,
    input  mem_addr, mem_wdata, MemRead, MemWrite
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_rdata,
    output stall, load_data, load_valid, err,
    output mem_addr, mem_wdata, MemRead, MemWrite
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   MEM-stage initiator for a word-addressed data memory with combinational
//   read and posedge write. Converts byte/halfword/word loads and stores into
//   word accesses; sub-word stores use read-modify-write. Checks size,
//   alignment and range, extends load data and stalls the pipeline while busy.
// Ports
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : dmem_access_ctrl_if.slave (request, response and memory signals)
// Parameter
//   DEPTH : number of 32-bit words in the data memory
module dmem_access_ctrl #(
  parameter int unsigned DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  dmem_access_ctrl_if.slave  bus
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD     = 3'd1,
    ST     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4
  } state_t;

  state_t      state_reg, state_next;

  logic        write_reg;
  logic [1:0]  size_reg;
  logic        signed_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] merge_reg;
  logic [31:0] load_data_reg;
  logic        load_valid_reg;
  logic        err_reg;

  // Request checks, evaluated on the live inputs while IDLE
  logic [31:0] req_index;
  logic        size_illegal;
  logic        misaligned;
  logic        out_of_range;
  logic        req_bad;
  logic        accept;

  assign req_index    = {2'b00, bus.req_addr[31:2]};
  assign size_illegal = (bus.req_size == 2'b11);
  assign misaligned   = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign out_of_range = (req_index >= DEPTH_W);
  assign req_bad      = size_illegal || misaligned || out_of_range;
  assign accept       = (state_reg == IDLE) && bus.req_valid;

  // Load lane selection and extension from the combinational read word
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  always_comb begin
    rd_byte = 8'h00;
    case (addr_reg[1:0])
      2'd0:    rd_byte = bus.mem_rdata[7:0];
      2'd1:    rd_byte = bus.mem_rdata[15:8];
      2'd2:    rd_byte = bus.mem_rdata[23:16];
      default: rd_byte = bus.mem_rdata[31:24];
    endcase
    rd_half = addr_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    load_ext = bus.mem_rdata;
    case (size_reg)
      2'b00:   load_ext = {{24{signed_reg & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{16{signed_reg & rd_half[15]}}, rd_half};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  // Merge word for RMW: each byte lane either keeps the word read back in
  // RMW_RD or takes the matching byte of the right-aligned store data.
  logic [31:0] merged;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] lane_src;

      // Halfword stores hit both lanes of the addressed half; the even lane
      // takes wdata[7:0] and the odd lane wdata[15:8].
      assign lane_hit = (size_reg == 2'b00) ? (addr_reg[1:0] == 2'(gi))
                                            : (addr_reg[1] == 1'((gi >> 1) & 1));
      assign lane_src = ((size_reg == 2'b01) && ((gi & 1) == 1)) ? wdata_reg[15:8]
                                                                 : wdata_reg[7:0];
      assign merged[8*gi +: 8] = lane_hit ? lane_src : merge_reg[8*gi +: 8];
    end
  endgenerate

  // Next-state and state-decoded memory strobes
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  always_comb begin
    state_next = state_reg;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;

    case (state_reg)
      IDLE: begin
        if (accept && !req_bad) begin
          if (!bus.req_write)
            state_next = LD;
          else if (bus.req_size == 2'b10)
            state_next = ST;
          else
            state_next = RMW_RD;
        end
      end
      LD: begin
        mem_read   = 1'b1;
        mem_addr   = {2'b00, addr_reg[31:2]};
        state_next = IDLE;
      end
      ST: begin
        mem_write  = 1'b1;
        mem_addr   = {2'b00, addr_reg[31:2]};
        mem_wdata  = wdata_reg;
        state_next = IDLE;
      end
      RMW_RD: begin
        mem_read   = 1'b1;
        mem_addr   = {2'b00, addr_reg[31:2]};
        state_next = RMW_WR;
      end
      RMW_WR: begin
        mem_write  = 1'b1;
        mem_addr   = {2'b00, addr_reg[31:2]};
        mem_wdata  = merged;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers. An asynchronous reset drops the state to
  // IDLE, so the decoded strobes fall at once and a half-done RMW never writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      write_reg      <= 1'b0;
      size_reg       <= 2'b00;
      signed_reg     <= 1'b0;
      addr_reg       <= 32'h0;
      wdata_reg      <= 32'h0;
      merge_reg      <= 32'h0;
      load_data_reg  <= 32'h0;
      load_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      load_valid_reg <= (state_reg == LD);
      err_reg        <= accept && req_bad;

      if (accept) begin
        write_reg  <= bus.req_write;
        size_reg   <= bus.req_size;
        signed_reg <= bus.req_signed;
        addr_reg   <= bus.req_addr;
        wdata_reg  <= bus.req_wdata;
      end

      if (state_reg == LD)
        load_data_reg <= load_ext;

      if (state_reg == RMW_RD)
        merge_reg <= bus.mem_rdata;
    end
  end

  assign bus.stall      = (state_reg != IDLE);
  assign bus.load_data  = load_data_reg;
  assign bus.load_valid = load_valid_reg;
  assign bus.err        = err_reg;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.MemRead    = mem_read;
  assign bus.MemWrite   = mem_write;

  // write_reg is kept with the latched request; the state already encodes
  // the direction, so it is only folded in here to keep it referenced.
  logic unused_ok;
  assign unused_ok = write_reg;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl
//   Directed and random transactions against dmem_access_ctrl with a simple
//   word memory attached and a reference model of the expected results.
module tb_dmem_access_ctrl;
  localparam int DEPTH = 256;

  logic clk;
  logic rst;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached data memory: combinational read, posedge write
  logic [31:0] sim_mem [0:DEPTH-1];
  logic        mem_init;
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;
  int          wr_total;

  function automatic logic [31:0] pattern(input int i);
    return (32'(i) * 32'h0100_0193) ^ 32'h5A5A_C3C3;
  endfunction

  assign bus.mem_rdata = (bus.mem_addr < 32'(DEPTH)) ? sim_mem[bus.mem_addr[7:0]]
                                                     : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) sim_mem[i] <= pattern(i);
    end else if (pre_we) begin
      sim_mem[pre_idx] <= pre_data;
    end else if (bus.MemWrite && (bus.mem_addr < 32'(DEPTH))) begin
      sim_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (bus.MemWrite) wr_total <= wr_total + 1;
  end

  // Reference model state
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] last_load;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic sgn, input logic [31:0] addr);
    logic [31:0] v;
    v = word >> (int'(addr[1:0]) * 8);
    if (size == 2'b00) begin
      v = v & 32'hFF;
      if (sgn && (v >= 32'h80)) v = v | 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = v & 32'hFFFF;
      if (sgn && (v >= 32'h8000)) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] size,
                                              input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    sh = int'(addr[1:0]) * 8;
    if (size == 2'b10) return wd;
    mask = (size == 2'b00) ? 32'hFF : 32'hFFFF;
    return (old & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_idx  = 8'(idx);
    pre_data = data;
    ref_mem[idx] = data;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Issue one request, watch four cycles, and compare against the model.
  task automatic run_req(input logic w, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd);
    bit          bad;
    int          idx;
    int          exp_stall, exp_rd, exp_wr, exp_lv;
    logic [31:0] exp_word;
    int          stall_cnt, rd_cnt, wr_cnt, lv_cnt, err_cnt, both_cnt, lv_at;
    logic [31:0] rd_addr, wr_addr, wr_data, lv_data;
    string       tg;

    idx = int'(addr >> 2);
    bad = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
          (size == 2'b10 && addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH));
    exp_stall = 0; exp_rd = 0; exp_wr = 0; exp_lv = 0;
    exp_word  = 32'h0;
    if (!bad) begin
      if (!w) begin
        exp_stall = 1; exp_rd = 1; exp_lv = 1;
        last_load = model_load(ref_mem[idx], size, sgn, addr);
      end else begin
        exp_wr = 1;
        exp_stall = (size == 2'b10) ? 1 : 2;
        exp_rd    = (size == 2'b10) ? 0 : 1;
        ref_mem[idx] = model_store(ref_mem[idx], size, addr, wd);
        exp_word = ref_mem[idx];
      end
    end

    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;

    stall_cnt = 0; rd_cnt = 0; wr_cnt = 0; lv_cnt = 0; err_cnt = 0; both_cnt = 0;
    lv_at = 0; rd_addr = 0; wr_addr = 0; wr_data = 0; lv_data = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus.stall) stall_cnt++;
      if (bus.MemRead) begin rd_cnt++; rd_addr = bus.mem_addr; end
      if (bus.MemWrite) begin wr_cnt++; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata; end
      if (bus.MemRead && bus.MemWrite) both_cnt++;
      if (bus.load_valid) begin lv_cnt++; lv_at = k; lv_data = bus.load_data; end
      if (bus.err) err_cnt++;
    end

    tg = $sformatf("w%0d s%0d a%h", w, size, addr);
    $display("REQ %s wd=%h bad=%0d stall=%0d rd=%0d wr=%0d lv=%0d err=%0d",
             tg, wd, bad, stall_cnt, rd_cnt, wr_cnt, lv_cnt, err_cnt);
    check({tg, " err_cnt"},   32'(err_cnt),   bad ? 32'd1 : 32'd0);
    check({tg, " stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    check({tg, " rd_cnt"},    32'(rd_cnt),    32'(exp_rd));
    check({tg, " wr_cnt"},    32'(wr_cnt),    32'(exp_wr));
    check({tg, " lv_cnt"},    32'(lv_cnt),    32'(exp_lv));
    check({tg, " rd_wr_both"}, 32'(both_cnt), 32'd0);
    check({tg, " load_data"}, bus.load_data,  last_load);
    if (exp_rd != 0) check({tg, " rd_addr"}, rd_addr, 32'(idx));
    if (exp_lv != 0) begin
      check({tg, " lv_cycle"}, 32'(lv_at), 32'd2);
      check({tg, " lv_data"},  lv_data,    last_load);
    end
    if (exp_wr != 0) begin
      check({tg, " wr_addr"}, wr_addr, 32'(idx));
      check({tg, " wr_data"}, wr_data, exp_word);
      check({tg, " mem_word"}, sim_mem[idx], exp_word);
    end
  endtask

  initial begin
    int wr_before;
    logic [31:0] a;

    rst = 1'b1;
    mem_init = 1'b1;
    pre_we = 1'b0; pre_idx = 8'h0; pre_data = 32'h0;
    wr_total = 0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pattern(i);
    last_load = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst stall",      32'(bus.stall),      32'd0);
    check("rst load_data",  bus.load_data,       32'h0);
    check("rst load_valid", 32'(bus.load_valid), 32'd0);
    check("rst err",        32'(bus.err),        32'd0);
    check("rst MemRead",    32'(bus.MemRead),    32'd0);
    check("rst MemWrite",   32'(bus.MemWrite),   32'd0);
    check("rst mem_addr",   bus.mem_addr,        32'h0);
    check("rst mem_wdata",  bus.mem_wdata,       32'h0);
    @(negedge clk);
    mem_init = 1'b0;
    rst = 1'b0;

    // Directed cases
    poke(2, 32'h0000_000B);
    poke(1, 32'h0000_80F1);
    run_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    check("tp lw 0x08", bus.load_data, 32'h0000_000B);
    run_req(1'b0, 2'b00, 1'b1, 32'h04, 32'h0);
    check("tp lb 0x04", bus.load_data, 32'hFFFF_FFF1);
    run_req(1'b0, 2'b01, 1'b0, 32'h04, 32'h0);
    check("tp lhu 0x04", bus.load_data, 32'h0000_80F1);
    run_req(1'b0, 2'b01, 1'b1, 32'h06, 32'h0);
    check("tp lh 0x06", bus.load_data, 32'h0000_0000);
    run_req(1'b1, 2'b00, 1'b0, 32'h0B, 32'h0000_00AA);
    check("tp sb word2", sim_mem[2], 32'hAA00_000B);
    run_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    check("tp lw after sb", bus.load_data, 32'hAA00_000B);
    run_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    run_req(1'b1, 2'b01, 1'b0, 32'h03, 32'h1234);
    run_req(1'b0, 2'b11, 1'b0, 32'h00, 32'h0);
    check("tp ld held after errs", bus.load_data, 32'hAA00_000B);
    run_req(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFE_F00D);
    run_req(1'b1, 2'b10, 1'b0, 32'h3FC, 32'h1234_5678);
    check("tp sw word255", sim_mem[255], 32'h1234_5678);

    // Reset in the middle of a halfword RMW
    @(negedge clk);
    wr_before = wr_total;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0E; bus.req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("rmw_rst MemRead before", 32'(bus.MemRead), 32'd1);
    rst = 1'b1;
    #1;
    check("rmw_rst MemRead after", 32'(bus.MemRead),  32'd0);
    check("rmw_rst MemWrite",      32'(bus.MemWrite), 32'd0);
    check("rmw_rst stall",         32'(bus.stall),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_load = 32'h0;
    repeat (3) @(negedge clk);
    $display("RST_RMW writes=%0d word3=%h", wr_total - wr_before, sim_mem[3]);
    check("rmw_rst no write", 32'(wr_total - wr_before), 32'd0);
    check("rmw_rst word3",    sim_mem[3], ref_mem[3]);
    check("rmw_rst load_data", bus.load_data, 32'h0);

    // Random transactions
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) a = 32'h400 + 32'($urandom_range(0, 4095));
      else                           a = 32'($urandom_range(0, 1023));
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), a, $urandom);
    end

    for (int i = 0; i < DEPTH; i += 17)
      check($sformatf("final mem[%0d]", i), sim_mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
